// File: rtl/mult_engine_pkg.sv
// Types and widths shared by the multiply engine, its counter and interface.
`include "constants.svh"

package mult_engine_pkg;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } states_t;
endpackage

// File: rtl/mult_engine_if.sv
// Run-request / result bus between the stimulus driver (master) and the engine (slave).
// start/data_in: start is a request sampled only when the engine is idle; data_in must be
// stable around every sampling edge. valid is a one-cycle strobe marking a new data_out.
interface mult_engine_if;
  import mult_engine_pkg::*;

  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic [DATA_W-1:0] data_out;
  logic              busy;

  modport master (
    output start,
    output data_in,
    input  valid,
    input  data_out,
    input  busy
  );

  modport slave (
    input  start,
    input  data_in,
    output valid,
    output data_out,
    output busy
  );
endinterface

// File: rtl/constants.svh
// Shared build constants for the multiply engine and its bench.
`ifndef MULT_ENGINE_CONSTANTS_SVH
`define MULT_ENGINE_CONSTANTS_SVH

`define MAGIC_NUMBER 3
`define MAX_COUNT 255

`endif

// File: rtl/mult_engine_iter_counter.sv
// Operand counter for one run: cleared at run start, flags the last operand cycle.
`include "constants.svh"

module iter_counter
  import mult_engine_pkg::*;
#(
  parameter int ITERATIONS = `MAGIC_NUMBER
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERATIONS - 1);
  localparam logic [CNT_W:0]   MAX_CNT  = (CNT_W + 1)'(`MAX_COUNT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == LAST_CNT);

  // ITERATIONS is bounded below MAX_COUNT, so this can only fire on a logic fault.
  count_range_a : assert property (@(posedge clk) disable iff (rst)
    ({1'b0, count_q} < MAX_CNT))
    else $error("iter_counter: count %0d reached MAX_COUNT", count_q);
endmodule

// File: rtl/mult_engine.sv
// Multiplies ITERATIONS consecutive data_in samples (low 8 bits kept each step)
// after a start request and strobes the product out with a one-cycle valid.
`include "constants.svh"

module mult_engine
  import mult_engine_pkg::*;
#(
  parameter int ITERATIONS = `MAGIC_NUMBER
) (
  input  logic           clk,
  input  logic           rst,
  mult_engine_if.slave   bus,
  output states_t        state_o
);
  if (ITERATIONS < 1 || ITERATIONS >= `MAX_COUNT) begin : g_bad_iterations
    $error("mult_engine: ITERATIONS=%0d outside 1..MAX_COUNT-1", ITERATIONS);
  end

  states_t             state_q;
  logic [DATA_W-1:0]   acc_q;
  logic [DATA_W-1:0]   acc_d;
  logic [DATA_W-1:0]   data_out_q;
  logic                valid_q;
  logic                busy_q;
  logic [2*DATA_W-1:0] prod_full;
  logic                cnt_clear;
  logic                cnt_en;
  logic                cnt_tc;

  // Full-width product, then silent truncation: overflow never saturates.
  assign prod_full = {{DATA_W{1'b0}}, acc_q} * {{DATA_W{1'b0}}, bus.data_in};
  assign acc_d     = prod_full[DATA_W-1:0];

  assign cnt_clear = (state_q == IDLE) && bus.start;
  assign cnt_en    = (state_q == RUN) && !cnt_tc;

  iter_counter #(
    .ITERATIONS (ITERATIONS)
  ) u_iter_counter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (cnt_clear),
    .en_i    (cnt_en),
    .tc_o    (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          if (bus.start) begin
            acc_q   <= DATA_W'(1);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (cnt_tc) begin
            data_out_q <= acc_d;
            valid_q    <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          // start is deliberately not looked at here; requests are never queued.
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.valid    = valid_q;
  assign bus.data_out = data_out_q;
  assign bus.busy     = busy_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_mult_engine.sv
// Directed bench for mult_engine: a 3-operand instance and a 1-operand instance.
module tb_mult_engine;
  import mult_engine_pkg::*;

  logic    clk;
  logic    rst;
  states_t state_a;
  states_t state_b;
  int      checks;
  int      failures;

  mult_engine_if bus_a ();
  mult_engine_if bus_b ();

  mult_engine #(.ITERATIONS(3)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_a),
    .state_o (state_a)
  );

  mult_engine #(.ITERATIONS(1)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_b),
    .state_o (state_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic st, input logic [7:0] d);
    bus_a.start   = st;
    bus_a.data_in = d;
    tick();
  endtask

  task automatic drive_b(input logic st, input logic [7:0] d);
    bus_b.start   = st;
    bus_b.data_in = d;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst           = 1'b1;
    bus_a.start   = 1'b0;
    bus_a.data_in = 8'h00;
    bus_b.start   = 1'b0;
    bus_b.data_in = 8'h00;
    tick();
    tick();
    checks++; if (bus_a.valid !== 1'b0) begin failures++; $display("FAIL reset_valid_a: got %b want 0", bus_a.valid); end
    checks++; if (bus_a.data_out !== 8'h00) begin failures++; $display("FAIL reset_data_a: got %h want 00", bus_a.data_out); end
    checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("FAIL reset_busy_a: got %b want 0", bus_a.busy); end
    checks++; if (state_a !== IDLE) begin failures++; $display("FAIL reset_state_a: got %0d want %0d", state_a, IDLE); end
    checks++; if (bus_b.valid !== 1'b0 || bus_b.data_out !== 8'h00 || bus_b.busy !== 1'b0) begin
      failures++; $display("FAIL reset_b: got valid=%b data=%h busy=%b want 0/00/0", bus_b.valid, bus_b.data_out, bus_b.busy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int busy_cycles;
    busy_cycles = 0;
    drive_a(1'b1, 8'h00);
    if (bus_a.busy === 1'b1) busy_cycles++;
    checks++; if (bus_a.valid !== 1'b0) begin failures++; $display("FAIL basic_valid_e0: got %b want 0", bus_a.valid); end
    drive_a(1'b0, 8'd2);
    if (bus_a.busy === 1'b1) busy_cycles++;
    drive_a(1'b0, 8'd3);
    if (bus_a.busy === 1'b1) busy_cycles++;
    checks++; if (bus_a.valid !== 1'b0) begin failures++; $display("FAIL basic_valid_e2: got %b want 0", bus_a.valid); end
    drive_a(1'b0, 8'd4);
    if (bus_a.busy === 1'b1) busy_cycles++;
    checks++; if (bus_a.valid !== 1'b1) begin failures++; $display("FAIL basic_valid_e3: got %b want 1", bus_a.valid); end
    checks++; if (bus_a.data_out !== 8'h18) begin failures++; $display("FAIL basic_data: got %h want 18", bus_a.data_out); end
    drive_a(1'b0, 8'h00);
    if (bus_a.busy === 1'b1) busy_cycles++;
    checks++; if (bus_a.valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop: got %b want 0", bus_a.valid); end
    checks++; if (bus_a.data_out !== 8'h18) begin failures++; $display("FAIL basic_data_hold: got %h want 18", bus_a.data_out); end
    checks++; if (busy_cycles != 4) begin failures++; $display("FAIL basic_busy_len: got %0d want 4", busy_cycles); end
    checks++; if (state_a !== IDLE) begin failures++; $display("FAIL basic_state_end: got %0d want %0d", state_a, IDLE); end
  endtask

  task automatic test_overflow();
    drive_a(1'b1, 8'h00);
    drive_a(1'b0, 8'd16);
    drive_a(1'b0, 8'd16);
    drive_a(1'b0, 8'd7);
    checks++; if (bus_a.valid !== 1'b1) begin failures++; $display("FAIL ovf_valid: got %b want 1", bus_a.valid); end
    checks++; if (bus_a.data_out !== 8'h00) begin failures++; $display("FAIL ovf_data: got %h want 00", bus_a.data_out); end
    drive_a(1'b0, 8'h00);
  endtask

  task automatic test_held_start();
    logic exp_v;
    int   pulses;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      drive_a(1'b1, 8'd1);
      exp_v = ((i % 5) == 3);
      if (bus_a.valid === 1'b1) pulses++;
      checks++; if (bus_a.valid !== exp_v) begin failures++; $display("FAIL held_valid[%0d]: got %b want %b", i, bus_a.valid, exp_v); end
      if (exp_v) begin
        checks++; if (bus_a.data_out !== 8'h01) begin failures++; $display("FAIL held_data[%0d]: got %h want 01", i, bus_a.data_out); end
      end
    end
    checks++; if (pulses != 4) begin failures++; $display("FAIL held_pulses: got %0d want 4", pulses); end
    drive_a(1'b0, 8'h00);
    drive_a(1'b0, 8'h00);
  endtask

  task automatic test_repulse();
    drive_a(1'b1, 8'h00);
    drive_a(1'b1, 8'd5);
    checks++; if (bus_a.valid !== 1'b0) begin failures++; $display("FAIL repulse_valid_e1: got %b want 0", bus_a.valid); end
    drive_a(1'b0, 8'd5);
    checks++; if (bus_a.valid !== 1'b0) begin failures++; $display("FAIL repulse_valid_e2: got %b want 0", bus_a.valid); end
    drive_a(1'b0, 8'd5);
    checks++; if (bus_a.valid !== 1'b1) begin failures++; $display("FAIL repulse_valid_e3: got %b want 1", bus_a.valid); end
    checks++; if (bus_a.data_out !== 8'h7D) begin failures++; $display("FAIL repulse_data: got %h want 7d", bus_a.data_out); end
    drive_a(1'b1, 8'h00);
    checks++; if (state_a !== IDLE || bus_a.busy !== 1'b0) begin
      failures++; $display("FAIL repulse_done_ignores_start: got state=%0d busy=%b want %0d/0", state_a, bus_a.busy, IDLE);
    end
    for (int i = 0; i < 6; i++) begin
      drive_a(1'b0, 8'h00);
      checks++; if (bus_a.valid !== 1'b0 || bus_a.busy !== 1'b0) begin
        failures++; $display("FAIL repulse_quiet[%0d]: got valid=%b busy=%b want 0/0", i, bus_a.valid, bus_a.busy);
      end
    end
  endtask

  task automatic test_async_reset();
    drive_a(1'b1, 8'h00);
    drive_a(1'b0, 8'd2);
    drive_a(1'b0, 8'd3);
    checks++; if (bus_a.busy !== 1'b1) begin failures++; $display("FAIL areset_pre_busy: got %b want 1", bus_a.busy); end
    rst = 1'b1;
    #1;
    checks++; if (bus_a.valid !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.data_out !== 8'h00) begin
      failures++; $display("FAIL areset_outputs: got valid=%b busy=%b data=%h want 0/0/00", bus_a.valid, bus_a.busy, bus_a.data_out);
    end
    checks++; if (state_a !== IDLE) begin failures++; $display("FAIL areset_state: got %0d want %0d", state_a, IDLE); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_a(1'b0, 8'd9);
      checks++; if (bus_a.valid !== 1'b0 || bus_a.busy !== 1'b0) begin
        failures++; $display("FAIL areset_no_resume[%0d]: got valid=%b busy=%b want 0/0", i, bus_a.valid, bus_a.busy);
      end
    end
    drive_a(1'b1, 8'h00);
    drive_a(1'b0, 8'd2);
    drive_a(1'b0, 8'd3);
    drive_a(1'b0, 8'd4);
    checks++; if (bus_a.valid !== 1'b1 || bus_a.data_out !== 8'h18) begin
      failures++; $display("FAIL areset_rerun: got valid=%b data=%h want 1/18", bus_a.valid, bus_a.data_out);
    end
    drive_a(1'b0, 8'h00);
  endtask

  task automatic test_single_iter();
    drive_b(1'b1, 8'h00);
    checks++; if (bus_b.busy !== 1'b1 || bus_b.valid !== 1'b0) begin
      failures++; $display("FAIL single_e0: got busy=%b valid=%b want 1/0", bus_b.busy, bus_b.valid);
    end
    drive_b(1'b0, 8'hFF);
    checks++; if (bus_b.valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1", bus_b.valid); end
    checks++; if (bus_b.data_out !== 8'hFF) begin failures++; $display("FAIL single_data: got %h want ff", bus_b.data_out); end
    drive_b(1'b0, 8'h00);
    checks++; if (bus_b.valid !== 1'b0 || bus_b.busy !== 1'b0 || bus_b.data_out !== 8'hFF) begin
      failures++; $display("FAIL single_after: got valid=%b busy=%b data=%h want 0/0/ff", bus_b.valid, bus_b.busy, bus_b.data_out);
    end
    drive_b(1'b1, 8'h00);
    drive_b(1'b0, 8'h03);
    checks++; if (bus_b.valid !== 1'b1 || bus_b.data_out !== 8'h03) begin
      failures++; $display("FAIL single_rerun: got valid=%b data=%h want 1/03", bus_b.valid, bus_b.data_out);
    end
    drive_b(1'b0, 8'h00);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_held_start();
    test_repulse();
    test_async_reset();
    test_single_iter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_engine.md
# mult_engine

Producer side of the start/data_in → valid/data_out handshake whose consumer is the `check` block. On a `start` pulse, the block multiplies `ITERATIONS` consecutive `data_in` samples, truncating the product to 8 bits. It then presents the product on `data_out` with a one-cycle `valid` strobe. It is the DUT that the checker scores, and sits between the stimulus driver and `check` in the top-level bench.

## Interface
- `ITERATIONS`, default `` `MAGIC_NUMBER `` (from `constants.svh`): number of `data_in` samples multiplied per run. Legal range 1 .. `` `MAX_COUNT ``−1; elaboration-time `$error` otherwise.
- `clk`  input  1  sole clock; all state changes on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  run request; sampled only in IDLE.
- `data_in`  input  8  operand stream; sampled every RUN cycle.
- `valid`  output  1  registered; high for exactly one cycle when `data_out` holds a result.
- `data_out`  output  8  registered result; holds last value until next result.
- `busy`  output  1  registered; high in RUN and DONE.

## Operation
- State machine, one-hot-free enum `{IDLE, RUN, DONE}`:
  - IDLE: `valid`=0, `busy`=0.
    - `start`=1 → `count`<=0, `acc`<=8'd1, `busy`<=1, go RUN.
    - `start`=0 → stay.
  - RUN: each cycle `acc`<=(`acc`×`data_in`)[7:0].
    - If `count`==`ITERATIONS`−1: `data_out`<=(`acc`×`data_in`)[7:0], `valid`<=1, go DONE.
    - Else `count`<=`count`+1.
  - DONE: `valid`<=0, `busy`<=0, go IDLE unconditionally.
- `start` is ignored in RUN and DONE, with no queuing. A request only takes effect when sampled in IDLE.
- Arithmetic rules:
  - 8×8 product is computed full width (16 bits), then truncated to the low 8 bits each cycle.
  - Overflow is silent and never saturates.
  - `count` is 8 bits and never wraps, since `ITERATIONS` is bounded below `` `MAX_COUNT ``.
- Assertion: `count` >= `` `MAX_COUNT `` at any time → `$error`. This state is unreachable.
- Reset (async, any state including mid-RUN):
  - state=IDLE, `count`=0, `acc`=0.
  - `valid`=0, `data_out`=8'h00, `busy`=0.
  - A partial run is discarded. After deassertion, the block waits for a fresh `start`.

## Timing
- Edge E0 samples `start`=1 in IDLE.
- `data_in` is sampled at edges E1 .. E`ITERATIONS`.
- `valid`/`data_out` update at edge E`ITERATIONS`. `valid` is high during the following cycle and drops at E`ITERATIONS`+1.
- Earliest next `start` sample is at E`ITERATIONS`+2. With `start` held high, the run period is `ITERATIONS`+2 cycles.
- Stimulus must hold `data_in` stable around each sampling edge. The block has no input back-pressure.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- `mult_engine_pkg`: state enum `states_t {IDLE, RUN, DONE}` and localparam `DATA_W`=8.
- `` `MAGIC_NUMBER `` and `` `MAX_COUNT `` remain in `constants.svh`, which is included by both the package and the bench.
- One sub-module is natural: `iter_counter`.
  - Inputs: clear and enable.
  - Output: terminal-count flag when `count`==`ITERATIONS`−1.
  - Carries the `` `MAX_COUNT `` range assertion.
- The datapath and FSM stay in the top module.

## Test plan
- `ITERATIONS`=3, pulse `start`, `data_in`=2,3,4 at E1..E3 → `valid`=1 for one cycle after E3, `data_out`=8'h18; `busy` high for 4 cycles.
- Overflow: `ITERATIONS`=3, `data_in`=16,16,7 → `data_out`=8'h00 (256 truncates to 0, then ×7 stays 0); `valid` pulse still produced.
- `start` held high for 20 cycles, `ITERATIONS`=3, `data_in`=1 constant → `valid` pulses every 5 cycles, each with `data_out`=8'h01.
- `start` re-pulsed during RUN, `data_in`=5,5,5 → single result 8'h7D; no extra `valid`; run length unchanged.
- Reset asserted at E2 of a run → all outputs 0 immediately (asynchronous). No `valid` until a new `start`; the next run with 2,3,4 yields 8'h18.
- `ITERATIONS`=1, `start` then `data_in`=8'hFF at E1 → `data_out`=8'hFF, `valid` high during the cycle after E1.
